// File: rtl/pixel_scanout.sv
// Pixel scan-out engine: free-running raster timing, line-buffer address
// generation, line-fill requests and a 16-entry palette lookup.
// Video outputs lag the raster counters by two clocks.
module pixel_scanout #(
  parameter int unsigned H_VISIBLE   = 1280,
  parameter int unsigned H_FRONT     = 48,
  parameter int unsigned H_SYNC      = 112,
  parameter int unsigned H_BACK      = 248,
  parameter int unsigned V_VISIBLE   = 1024,
  parameter int unsigned V_FRONT     = 1,
  parameter int unsigned V_SYNC      = 3,
  parameter int unsigned V_BACK      = 38,
  parameter logic        SYNC_ACTIVE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] pixel_addr,
  input  logic [3:0]  pixel_index,
  output logic        line_request,
  output logic [9:0]  line_number,
  input  logic        pal_we,
  input  logic [3:0]  pal_index,
  input  logic [23:0] pal_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  // One spare bit so every region boundary, including the total, is representable.
  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_VIS_M1   = VW'(V_VISIBLE - 1);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  // Stage 0: raster counters and the registered address / request outputs
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [10:0]   addr_q, addr_d;
  logic          lreq_q, lreq_d;
  logic [9:0]    lnum_q, lnum_d;

  // Stage-0 timing flags decoded from the live counters
  logic          de0_c, hs0_c, vs0_c;

  // Stage 1 / stage 2 pipeline
  logic          de1_q, hs1_q, vs1_q;
  logic          de2_q, hs2_q, vs2_q;
  logic [23:0]   rgb_q, rgb_d;

  // Palette storage
  logic [23:0]   pal_q [16];

  // Next raster position; address and line request are precomputed from it
  // so they line up with the counter value they describe.
  always_comb begin
    hcount_d = hcount_q + HW'(1);
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
    end
    addr_d = (hcount_d < H_VIS_END) ? 11'(hcount_d) : 11'd0;
    lreq_d = (hcount_d == H_VIS_END) &&
             ((vcount_d < V_VIS_M1) || (vcount_d == V_LAST));
    lnum_d = lnum_q;
    if (lreq_d) begin
      lnum_d = (vcount_d == V_LAST) ? 10'd0 : 10'(vcount_d + VW'(1));
    end
  end

  // Counter and address/request registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
      addr_q   <= '0;
      lreq_q   <= 1'b0;
      lnum_q   <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      addr_q   <= addr_d;
      lreq_q   <= lreq_d;
      lnum_q   <= lnum_d;
    end
  end

  // Region decode for the current raster position
  always_comb begin
    de0_c = (hcount_q < H_VIS_END) && (vcount_q < V_VIS_END);
    hs0_c = ((hcount_q >= H_SYNC_BEG) && (hcount_q < H_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs0_c = ((vcount_q >= V_SYNC_BEG) && (vcount_q < V_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  // Palette lookup; pixel_index arrives during stage 1 alongside the delayed flags
  always_comb begin
    rgb_d = de1_q ? pal_q[pixel_index] : 24'd0;
  end

  // Two-stage delay of timing flags and registered colour output
  always_ff @(posedge clk) begin
    if (!reset) begin
      de1_q <= 1'b0;
      hs1_q <= ~SYNC_ACTIVE;
      vs1_q <= ~SYNC_ACTIVE;
      de2_q <= 1'b0;
      hs2_q <= ~SYNC_ACTIVE;
      vs2_q <= ~SYNC_ACTIVE;
      rgb_q <= '0;
    end else begin
      de1_q <= de0_c;
      hs1_q <= hs0_c;
      vs1_q <= vs0_c;
      de2_q <= de1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      rgb_q <= rgb_d;
    end
  end

  // Palette entries: grey ramp on reset, written entries visible from the next edge
  for (genvar gi = 0; gi < 16; gi++) begin : g_pal
    always_ff @(posedge clk) begin
      if (!reset) begin
        pal_q[gi] <= {3{8'(gi * 17)}};
      end else if (pal_we && (pal_index == 4'(gi))) begin
        pal_q[gi] <= pal_rgb;
      end
    end
  end

  assign pixel_addr   = addr_q;
  assign line_request = lreq_q;
  assign line_number  = lnum_q;
  assign de           = de2_q;
  assign hsync        = hs2_q;
  assign vsync        = vs2_q;
  assign red          = rgb_q[23:16];
  assign green        = rgb_q[15:8];
  assign blue         = rgb_q[7:0];

endmodule

// File: tb/tb_pixel_scanout.sv
// Scoreboard bench for pixel_scanout with small raster parameters.
// The driver predicts each cycle's outputs from the raster position
// (cycles since reset release) and a palette array; a monitor compares.
`timescale 1ns/1ps
module tb_pixel_scanout;

  localparam int unsigned HV = 8, HF = 2, HS = 2, HB = 2;
  localparam int unsigned VV = 4, VF = 1, VS = 1, VB = 1;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam int NCYC = 1100;

  logic        clk;
  logic        reset;
  logic [3:0]  pixel_index;
  logic        pal_we;
  logic [3:0]  pal_index;
  logic [23:0] pal_rgb;

  logic [10:0] pixel_addr, pixel_addr_n;
  logic        line_request, line_request_n;
  logic [9:0]  line_number, line_number_n;
  logic        hsync, vsync, de, hsync_n, vsync_n, de_n;
  logic [7:0]  red, green, blue, red_n, green_n, blue_n;

  typedef struct {
    logic [10:0] addr;
    logic        lreq;
    logic [9:0]  lnum;
    logic        de;
    logic        hs;   // sync region active (level-independent)
    logic        vs;
    logic [23:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int checks;
  int errors;

  pixel_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b1)
  ) u_dut (
    .clk(clk), .reset(reset), .pixel_addr(pixel_addr), .pixel_index(pixel_index),
    .line_request(line_request), .line_number(line_number),
    .pal_we(pal_we), .pal_index(pal_index), .pal_rgb(pal_rgb),
    .hsync(hsync), .vsync(vsync), .de(de), .red(red), .green(green), .blue(blue)
  );

  pixel_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b0)
  ) u_inv (
    .clk(clk), .reset(reset), .pixel_addr(pixel_addr_n), .pixel_index(pixel_index),
    .line_request(line_request_n), .line_number(line_number_n),
    .pal_we(pal_we), .pal_index(pal_index), .pal_rgb(pal_rgb),
    .hsync(hsync_n), .vsync(vsync_n), .de(de_n), .red(red_n), .green(green_n), .blue(blue_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raster position model: p = clocks since the last reset release
  function automatic int unsigned hpos(input int unsigned p);
    return p % HT;
  endfunction

  function automatic int unsigned vpos(input int unsigned p);
    return (p / HT) % VT;
  endfunction

  function automatic logic [10:0] addr_of(input int unsigned p);
    return (hpos(p) < HV) ? 11'(hpos(p)) : 11'd0;
  endfunction

  function automatic logic lreq_of(input int unsigned p);
    return (hpos(p) == HV) && ((vpos(p) + 1 < VV) || (vpos(p) == VT - 1));
  endfunction

  function automatic logic [9:0] lnum_of(input int unsigned p);
    return (vpos(p) == VT - 1) ? 10'd0 : 10'(vpos(p) + 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Monitor: one expectation per clock, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pixel_addr",   32'(pixel_addr),   32'(e.addr));
        chk("line_request", 32'(line_request), 32'(e.lreq));
        if (e.lreq) chk("line_number", 32'(line_number), 32'(e.lnum));
        chk("de",    32'(de),    32'(e.de));
        chk("hsync", 32'(hsync), 32'(e.hs));
        chk("vsync", 32'(vsync), 32'(e.vs));
        chk("red",   32'(red),   32'(e.rgb[23:16]));
        chk("green", 32'(green), 32'(e.rgb[15:8]));
        chk("blue",  32'(blue),  32'(e.rgb[7:0]));
        chk("inv_hsync", 32'(hsync_n), 32'(!e.hs));
        chk("inv_vsync", 32'(vsync_n), 32'(!e.vs));
        chk("inv_de",    32'(de_n),    32'(e.de));
      end
    end
  end

  // Driver and reference model
  initial begin
    int unsigned p, prev_p;
    bit          prev_rst, in_rst, rst_done, we;
    logic [3:0]  idx, widx;
    logic [23:0] wrgb;
    logic [10:0] a;
    logic [23:0] pal_m [16];
    exp_t        e;

    checks = 0;
    errors = 0;
    reset = 1'b0;
    pixel_index = '0;
    pal_we = 1'b0;
    pal_index = '0;
    pal_rgb = '0;
    p = 0;
    prev_p = 0;
    prev_rst = 1'b1;
    rst_done = 1'b0;
    for (int i = 0; i < 16; i++) pal_m[i] = {3{8'(i * 17)}};

    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      in_rst = 1'b0;
      we = 1'b0;
      widx = '0;
      wrgb = '0;
      // Line buffer emulation: data returned is the previous address
      a = addr_of(prev_p);
      idx = a[3:0];
      if (k < 3) begin
        in_rst = 1'b1;
      end else if (k < 500) begin
        // Overwrite entry 3 while it is being read, then see it next line
        if (p == 2 * FRAME + 4) begin
          we = 1'b1;
          widx = 4'd3;
          wrgb = 24'hFF0080;
        end
        // Mid-frame reset at line 2, pixel 5
        if (!rst_done && p == 3 * FRAME + 2 * HT + 5) begin
          in_rst = 1'b1;
          rst_done = 1'b1;
        end
      end else begin
        idx = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) begin
          we = 1'b1;
          widx = 4'($urandom_range(0, 15));
          wrgb = 24'($urandom);
        end
        if ($urandom_range(0, 149) == 0) in_rst = 1'b1;
      end

      reset = !in_rst;
      pixel_index = idx;
      pal_we = we;
      pal_index = widx;
      pal_rgb = wrgb;

      // Outputs expected during the following clock
      if (in_rst) begin
        e.addr = '0; e.lreq = 1'b0; e.lnum = '0;
        e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0; e.rgb = '0;
      end else begin
        e.addr = addr_of(p + 1);
        e.lreq = lreq_of(p + 1);
        e.lnum = lnum_of(p + 1);
        if (prev_rst) begin
          e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0;
        end else begin
          e.de = (hpos(prev_p) < HV) && (vpos(prev_p) < VV);
          e.hs = (hpos(prev_p) >= HV + HF) && (hpos(prev_p) < HV + HF + HS);
          e.vs = (vpos(prev_p) >= VV + VF) && (vpos(prev_p) < VV + VF + VS);
        end
        e.rgb = e.de ? pal_m[idx] : 24'h0;
      end
      exp_q.push_back(e);

      if (in_rst) begin
        for (int i = 0; i < 16; i++) pal_m[i] = {3{8'(i * 17)}};
      end else if (we) begin
        pal_m[widx] = wrgb;
      end
      prev_p = p;
      prev_rst = in_rst;
      p = in_rst ? 0 : p + 1;
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run bound
  initial begin
    #100000;
    $display("FAIL watchdog at %0t: simulation did not finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/pixel_scanout.md
PIXEL_SCANOUT -- requirements
Module: pixel_scanout

Interface
REQ-001 Parameter H_VISIBLE, default 1280, visible pixels per line.
REQ-002 Parameter H_FRONT, default 48; H_SYNC, default 112; H_BACK, default 248: horizontal porch and sync widths in pixels.
REQ-003 Parameter V_VISIBLE, default 1024; V_FRONT, default 1; V_SYNC, default 3; V_BACK, default 38: vertical widths in lines.
REQ-004 Parameter SYNC_ACTIVE, default 1'b1, the active level of hsync and vsync.
REQ-005 Port clk, input, 1, pixel clock; all logic on rising edge.
REQ-006 Port reset, input, 1, synchronous active-low reset.
REQ-007 Port pixel_addr, output, 11, line-buffer read address.
REQ-008 Port pixel_index, input, 4, line-buffer read data, valid one cycle after pixel_addr.
REQ-009 Port line_request, output, 1, one-cycle pulse asking upstream to fill the line buffer.
REQ-010 Port line_number, output, 10, visible line to be filled, valid while line_request is high.
REQ-011 Port pal_we, input, 1, palette write strobe.
REQ-012 Port pal_index, input, 4, palette entry to write.
REQ-013 Port pal_rgb, input, 24, palette value {R,G,B}.
REQ-014 Ports hsync, vsync, de, output, 1 each, aligned video timing.
REQ-015 Ports red, green, blue, output, 8 each, pixel colour.

Function
REQ-016 The block SHALL keep hcount over 0..H_TOTAL-1 (H_TOTAL = sum of the H widths) and vcount over 0..V_TOTAL-1; hcount wraps to 0 and vcount increments on the same cycle; vcount wraps to 0 after V_TOTAL-1.
REQ-017 Region order SHALL be visible, front porch, sync, back porch, on both axes, starting at count 0.
REQ-018 pixel_addr SHALL equal hcount while hcount < H_VISIBLE, and 0 otherwise.
REQ-019 Output latency SHALL be 2 cycles: the stage-0 counters produce the address; stage 1 captures pixel_index and delays the timing flags; stage 2 registers the palette lookup and the flags.
REQ-020 Stage-0 de SHALL be (hcount < H_VISIBLE) and (vcount < V_VISIBLE); hsync and vsync SHALL be at SYNC_ACTIVE exactly during their sync regions; all three SHALL be delayed 2 cycles to the outputs.
REQ-021 red, green, blue SHALL be palette[pixel_index] when delayed de is 1, and 0 otherwise.
REQ-022 line_request SHALL pulse for one cycle at hcount == H_VISIBLE of line v if v+1 < V_VISIBLE, with line_number = v+1.
REQ-023 line_request SHALL also pulse at hcount == H_VISIBLE of line V_TOTAL-1, with line_number = 0.
REQ-024 A palette write SHALL take effect on the next clock edge; a write and a read of the same entry in the same cycle SHALL return the old value.
REQ-025 The block SHALL NOT stall; underrun is the responsibility of upstream, which gets H_TOTAL-H_VISIBLE cycles between line_request and the first read of the line.

Reset
REQ-026 While reset is 0: hcount = 0, vcount = 0, pixel_addr = 0, line_request = 0, line_number = 0, de = 0, rgb = 0, hsync = vsync = ~SYNC_ACTIVE, and pipeline registers cleared.
REQ-027 Reset SHALL initialise palette entry i to {i,i} on every channel (grey ramp, i*17).
REQ-028 Reset asserted mid-frame SHALL take effect on the next edge; counting SHALL restart at 0,0 on the first edge after release.

Verification (small parameters: H 8/2/2/2, V 4/1/1/1)
REQ-029 Reset release, then one line -> pixel_addr 0..7 then 0 for 6 cycles; de high on cycles 2..9 after release.
REQ-030 Return pixel_index = pixel_addr[3:0] -> red = green = blue = 0x00, 0x11, ..., 0x77 across the visible pixels.
REQ-031 Full frame -> line_request at hcount 8 of lines 0,1,2 (line_number 1,2,3) and of line 6 (line_number 0); no pulse on lines 3,4,5.
REQ-032 Sync timing -> hsync active for delayed hcount 10..11; vsync active for the whole of line 5; SYNC_ACTIVE=0 inverts both.
REQ-033 pal_we with index 3 and value 0xFF0080, then pixel_index=3 -> output 0xFF,0x00,0x80; same-cycle read returns 0x33.
REQ-034 Reset pulsed at vcount 2, hcount 5 -> all outputs at reset values next cycle; after release, pixel_addr 0 and a full frame as in REQ-031.
